// File: rtl/fifo_byte_drain.sv
// Pops words from the circular word FIFO and streams each one out MSB byte first
// over an 8-bit valid/ready interface, while mirroring the FIFO occupancy.
module fifo_byte_drain #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int CNTWIDTH = 6
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                new_data,
  input  logic [WIDTH-1:0]    fifo_data,
  output logic                out_data,
  output logic [7:0]          byte_out,
  output logic                byte_valid,
  input  logic                byte_ready,
  output logic                last_byte,
  output logic [CNTWIDTH-1:0] level,
  output logic                empty,
  output logic                overflow
);

  localparam int NBYTES = WIDTH / 8;
  localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {IDLE, POP, SEND} state_t;

  state_t              state;
  logic [IDXW-1:0]     idx;
  logic [WIDTH-1:0]    shreg;
  logic [CNTWIDTH-1:0] level_nxt;
  logic                full;
  logic                ovf_set;
  logic                accept;
  logic                last_idx;

  assign full       = (level == CNTWIDTH'(DEPTH));
  assign empty      = (level == '0);
  assign byte_valid = (state == SEND);
  assign accept     = byte_valid && byte_ready;
  assign last_idx   = (idx == IDXW'(NBYTES - 1));
  assign last_byte  = byte_valid && last_idx;
  assign byte_out   = byte_valid ? shreg[WIDTH-1 -: 8] : 8'h00;

  // A write into a full FIFO is lost; a simultaneous pop makes room for it.
  always_comb begin
    level_nxt = level;
    ovf_set   = 1'b0;
    if (new_data && !out_data) begin
      if (full) ovf_set   = 1'b1;
      else      level_nxt = level + CNTWIDTH'(1);
    end else if (out_data && !new_data) begin
      level_nxt = level - CNTWIDTH'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      out_data <= 1'b0;
      idx      <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      level    <= level_nxt;
      out_data <= 1'b0;
      if (ovf_set) overflow <= 1'b1;
      case (state)
        IDLE: begin
          if (level != '0) begin
            state    <= POP;
            out_data <= 1'b1;
          end
        end
        POP: begin
          state <= SEND;
          idx   <= '0;
        end
        SEND: begin
          if (accept) begin
            idx <= idx + IDXW'(1);
            // Chain straight into the next pop using the post-update level.
            if (last_idx) begin
              if (level_nxt != '0) begin
                state    <= POP;
                out_data <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath register: only ever read while in SEND, so it needs no reset.
  always_ff @(posedge clock) begin
    if (state == POP)
      shreg <= fifo_data;
    else if (accept)
      shreg <= shreg << 8;
  end

endmodule

// File: tb/tb_fifo_byte_drain.sv
// Directed bench for fifo_byte_drain: a queue-based FIFO/byte-stream model checked
// every cycle, plus hand-computed per-cycle expectations for each scenario.
module tb_fifo_byte_drain;
  localparam int WIDTH = 32, DEPTH = 32, CNTWIDTH = 6, NB = WIDTH / 8;

  logic clock = 1'b0, reset = 1'b1, new_data = 1'b0, byte_ready = 1'b0;
  logic [WIDTH-1:0] fifo_data = '0;
  logic out_data, byte_valid, last_byte, empty, overflow;
  logic [7:0] byte_out;
  logic [CNTWIDTH-1:0] level;

  always #5 clock = ~clock;

  fifo_byte_drain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTWIDTH(CNTWIDTH)) dut (
    .clock(clock), .reset(reset), .new_data(new_data), .fifo_data(fifo_data),
    .out_data(out_data), .byte_out(byte_out), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .last_byte(last_byte), .level(level),
    .empty(empty), .overflow(overflow));

  int checks = 0, failures = 0, cyc = 0;
  logic [7:0] bo_log [512];
  logic bv_log [512], lb_log [512], od_log [512], ovf_log [512], emp_log [512];
  int lvl_log [512];

  logic [WIDTH-1:0] wr_word = '0;
  logic [WIDTH-1:0] fifo_q [$];
  logic [8:0] exp_q [$];
  int m_level = 0;
  bit m_ovf = 0, prev_stall = 0;
  logic [7:0] prev_byte = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: bench-side FIFO contents, byte queue of popped words, occupancy count.
  task automatic model_cycle();
    logic [WIDTH-1:0] w;
    if (reset) begin
      chk("rst_out_data", out_data, 0);
      chk("rst_byte_valid", byte_valid, 0);
      chk("rst_byte_out", byte_out, 0);
      chk("rst_last_byte", last_byte, 0);
      chk("rst_level", level, 0);
      chk("rst_empty", empty, 1);
      chk("rst_overflow", overflow, 0);
      fifo_q.delete();
      exp_q.delete();
      m_level = 0;
      m_ovf = 0;
      prev_stall = 0;
      return;
    end
    chk("level", level, m_level);
    chk("empty", empty, m_level == 0);
    chk("overflow", overflow, m_ovf);
    if (out_data) chk("pop_nonempty", m_level != 0, 1);
    if (prev_stall) begin
      chk("stall_valid", byte_valid, 1);
      chk("stall_byte", byte_out, prev_byte);
    end
    if (byte_valid) begin
      chk("byte_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        chk("byte_out", byte_out, exp_q[0][7:0]);
        chk("last_byte", last_byte, exp_q[0][8]);
      end
    end else begin
      chk("idle_byte", {last_byte, byte_out}, 0);
    end
    prev_stall = byte_valid && !byte_ready;
    prev_byte = byte_out;
    if (byte_valid && byte_ready && exp_q.size() != 0) void'(exp_q.pop_front());
    if (out_data && fifo_q.size() != 0) begin
      w = fifo_q.pop_front();
      for (int i = 0; i < NB; i++)
        exp_q.push_back({(i == NB - 1), w[WIDTH-1-8*i -: 8]});
    end
    if (new_data && fifo_q.size() < DEPTH) fifo_q.push_back(wr_word);
    if (new_data && !out_data) begin
      if (m_level == DEPTH) m_ovf = 1;
      else m_level++;
    end else if (out_data && !new_data) begin
      m_level--;
    end
  endtask

  task automatic step();
    @(negedge clock);
    if (cyc < 512) begin
      bo_log[cyc] = byte_out;  bv_log[cyc] = byte_valid; lb_log[cyc] = last_byte;
      od_log[cyc] = out_data;  ovf_log[cyc] = overflow;  emp_log[cyc] = empty;
      lvl_log[cyc] = int'(level);
    end
    model_cycle();
    cyc++;
    @(posedge clock);
    #1;
    fifo_data = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; new_data = 1'b0; byte_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic write_word(input logic [WIDTH-1:0] w);
    wr_word = w; new_data = 1'b1; step(); new_data = 1'b0;
  endtask

  logic [7:0] t1b [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
  int n;

  initial begin
    // Single word
    do_reset();
    byte_ready = 1'b1;
    write_word(32'hA1B2C3D4);
    repeat (8) step();
    for (int c = 0; c < 8; c++) chk($sformatf("t1_pop_c%0d", c), od_log[c], c == 2);
    chk("t1_level_c1", lvl_log[1], 1);
    chk("t1_valid_c2", bv_log[2], 0);
    for (int c = 3; c < 7; c++) begin
      chk($sformatf("t1_valid_c%0d", c), bv_log[c], 1);
      chk($sformatf("t1_byte_c%0d", c), bo_log[c], t1b[c-3]);
      chk($sformatf("t1_last_c%0d", c), lb_log[c], c == 6);
    end
    chk("t1_valid_c7", bv_log[7], 0);
    chk("t1_empty_c7", emp_log[7], 1);

    // Backpressure on the second byte
    do_reset();
    byte_ready = 1'b1;
    write_word(32'hA1B2C3D4);
    repeat (3) step();
    byte_ready = 1'b0;
    repeat (3) step();
    byte_ready = 1'b1;
    repeat (5) step();
    for (int c = 4; c < 8; c++) begin
      chk($sformatf("t2_hold_c%0d", c), bo_log[c], 8'hB2);
      chk($sformatf("t2_hvalid_c%0d", c), bv_log[c], 1);
    end
    chk("t2_c3_after", bo_log[8], 8'hC3);
    chk("t2_d4_byte", bo_log[9], 8'hD4);
    chk("t2_d4_last", lb_log[9], 1);
    n = 0;
    for (int c = 0; c < 12; c++) n += int'(od_log[c]);
    chk("t2_pop_count", n, 1);

    // Back-to-back words
    do_reset();
    byte_ready = 1'b1;
    write_word(32'h11223344);
    write_word(32'h55667788);
    repeat (11) step();
    chk("t3_level_c1", lvl_log[1], 1);
    chk("t3_level_c2", lvl_log[2], 2);
    chk("t3_level_c3", lvl_log[3], 1);
    chk("t3_level_c8", lvl_log[8], 0);
    chk("t3_last44", {lb_log[6], bo_log[6]}, 9'h144);
    chk("t3_bubble_pop", od_log[7], 1);
    chk("t3_bubble_valid", bv_log[7], 0);
    chk("t3_next55", bo_log[8], 8'h55);
    chk("t3_last88", {lb_log[11], bo_log[11]}, 9'h188);
    chk("t3_done", bv_log[12], 0);

    // Write coinciding with the pop
    do_reset();
    byte_ready = 1'b1;
    write_word(32'hCAFEBABE);
    step();
    write_word(32'h0F1E2D3C);
    repeat (10) step();
    chk("t4_pop_c2", od_log[2], 1);
    chk("t4_level_c3", lvl_log[3], 1);
    chk("t4_pop_c7", od_log[7], 1);
    chk("t4_w2_first", bo_log[8], 8'h0F);
    chk("t4_w2_last", {lb_log[11], bo_log[11]}, 9'h13C);

    // Overflow with the consumer stalled
    do_reset();
    byte_ready = 1'b0;
    for (int k = 0; k < 34; k++) write_word(32'h10000000 + k);
    repeat (3) step();
    chk("t5_pop_c2", od_log[2], 1);
    n = 0;
    for (int c = 3; c < 37; c++) n += int'(od_log[c]);
    chk("t5_no_more_pops", n, 0);
    chk("t5_stalled_byte", {bv_log[33], bo_log[33]}, 9'h110);
    chk("t5_level_c33", lvl_log[33], 32);
    chk("t5_ovf_c33", ovf_log[33], 0);
    chk("t5_level_c34", lvl_log[34], 32);
    chk("t5_ovf_c34", ovf_log[34], 1);
    chk("t5_ovf_c36", ovf_log[36], 1);
    byte_ready = 1'b1;
    repeat (180) step();
    chk("t5_drained_level", level, 0);
    chk("t5_ovf_sticky", overflow, 1);
    chk("t5_bytes_left", exp_q.size(), 0);

    // Asynchronous reset mid-word
    do_reset();
    byte_ready = 1'b1;
    write_word(32'h01020304);
    write_word(32'h05060708);
    repeat (2) step();
    chk("t6_second_byte", {bv_log[3], bo_log[3]}, 9'h101);
    chk("t6_presented", {byte_valid, byte_out}, 9'h102);
    chk("t6_level_before", level, 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_valid", byte_valid, 0);
    chk("t6_async_pop", out_data, 0);
    chk("t6_async_level", level, 0);
    chk("t6_async_byte", byte_out, 0);
    step(); step();
    reset = 1'b0;
    cyc = 0;
    repeat (8) step();
    n = 0;
    for (int c = 0; c < 8; c++) n += int'(bv_log[c]) + int'(od_log[c]);
    chk("t6_nothing_after", n, 0);
    chk("t6_ovf_cleared", overflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_byte_drain.md
# fifo_byte_drain

Downstream consumer of the circular word FIFO (`cfifo`). It mirrors the FIFO occupancy from the write strobe and its own pops, and pops one WIDTH-bit word whenever the FIFO holds data. Each popped word is serialized MSB-byte-first onto an 8-bit valid/ready byte stream that feeds the link/serial output stage.

## Interface
Parameters:
- WIDTH, 32, FIFO word width; must be a multiple of 8.
- DEPTH, 32, FIFO capacity in words; must match the FIFO instance.
- CNTWIDTH, 6, width of the `level` counter; must hold the value DEPTH.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- new_data  in  1  copy of the FIFO write strobe; one word is written per high cycle.
- fifo_data  in  WIDTH  FIFO `outData`; the word at the FIFO front.
- out_data  out  1  pop strobe to the FIFO `out_data` input; registered.
- byte_out  out  8  current byte of the serialized word.
- byte_valid  out  1  `byte_out` is valid.
- byte_ready  in  1  consumer accepts the byte when high together with `byte_valid`.
- last_byte  out  1  qualifies the final byte (byte WIDTH/8-1) of a word.
- level  out  CNTWIDTH  words currently held in the FIFO, as tracked by this block.
- empty  out  1  high when `level == 0`.
- overflow  out  1  sticky flag; set on a write while `level == DEPTH`.

## Operation
- Level counter:
  - +1 on `new_data`; −1 on a pop, i.e. a cycle with `out_data` high.
  - Both in the same cycle: `level` is unchanged.
  - `new_data` while `level == DEPTH` (and no pop): `level` holds at DEPTH and `overflow` is set.
  - `overflow` clears only on reset.
  - A pop is never issued while `level == 0`.
- FSM states:
  - IDLE:
    - `level != 0` → POP.
    - Otherwise stay in IDLE.
  - POP:
    - `out_data = 1` for exactly this one cycle.
    - At the edge that ends POP: `fifo_data` is captured into the shift register, the byte index is cleared to 0, and `level` is decremented.
    - → SEND unconditionally.
  - SEND:
    - `byte_valid = 1`; `byte_out` = shift register bits [WIDTH-1 : WIDTH-8].
    - `last_byte = 1` when the byte index equals WIDTH/8-1.
    - On `byte_valid && byte_ready`: shift the register left by 8 and increment the index.
    - On acceptance of the last byte: → POP if `level != 0` (the level value after this edge's update), else → IDLE.
- `byte_out` and `last_byte` hold stable while `byte_valid && !byte_ready`.
- `byte_out` is 0 outside SEND.
- Reset at any point, including mid-word, discards the partial word. No pop is issued for it, and its bytes are not resent.

## Timing
- Reset values: `out_data` 0, `byte_out` 0x00, `byte_valid` 0, `last_byte` 0, `level` 0, `empty` 1, `overflow` 0, state IDLE.
- Reset is asserted asynchronously and released synchronously to `clock` by the system.
- Latency from an empty, idle block:
  - `new_data` sampled at edge 0 → `level` = 1 in cycle 1.
  - `out_data` high in cycle 2.
  - First `byte_valid` in cycle 3.
- `fifo_data` must be valid throughout the POP cycle. The FIFO presents its front word combinationally, so this holds.
- Back-to-back words: one POP bubble cycle between the last byte of one word and the first byte of the next.
- Peak throughput: WIDTH/8 bytes per WIDTH/8+1 cycles.
- `empty` is combinational from `level`.
- All other outputs are registered or decoded from registered state only.
- No combinational path from `byte_ready` to `out_data`.

## Test plan
- **Single word:** write 0xA1B2C3D4 at edge 0, `byte_ready` = 1.
  - `out_data` pulses only in cycle 2.
  - Bytes A1, B2, C3, D4 appear in cycles 3–6, with `last_byte` only on D4.
  - Back in IDLE with `empty` = 1 in cycle 7.
- **Backpressure:** same word, `byte_ready` low for 3 cycles while B2 is presented.
  - B2 is held stable with `byte_valid` = 1 during the stall.
  - C3 follows the cycle after `byte_ready` returns high.
  - No extra `out_data` pulse.
- **Back-to-back:** write 0x11223344 then 0x55667788 on consecutive cycles, `byte_ready` = 1.
  - Byte 0x44 (last byte) is followed by one POP cycle, then 0x55.
  - `level` sequence is 1, 2, 1, ..., 0.
- **Simultaneous write and pop:** `level` = 1 in IDLE, `new_data` asserted during the POP cycle.
  - `level` stays 1 after that edge.
  - The next POP follows immediately after word 1's last byte.
- **Overflow:** `byte_ready` = 0, issue 34 writes.
  - The first word is popped and stalls in SEND.
  - `level` reaches 32 after write 33.
  - Write 34 sets `overflow` = 1 with `level` held at 32; `overflow` stays set until reset.
- **Reset mid-word:** assert `reset` while the second byte is presented.
  - `byte_valid`, `out_data` and `level` go to 0 immediately, without waiting for a clock edge.
  - After release with no writes, no bytes are emitted.
